read_stage: RTL and testbench

//  Register-read / decode stage of the flat RISC-V (RV32I) CPU. Holds the 32x32 integer register

---
 rtl/read_stage.sv | 93 +++++++++
 tb/tb_read_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/read_stage.sv
// Register-read / decode stage of the RV32I pipeline: 32x32 register file with write-first
// bypass, rs1/rs2 operand read, immediate decode, and one pipeline register toward execute.
module read_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR,
  input  logic [31:0] WB_data,
  input  logic [4:0]  WB_address,
  input  logic [31:0] PC,
  output logic [31:0] IR_out,
  output logic [31:0] A_out,
  output logic [31:0] B_out,
  output logic [31:0] PC_out,
  output logic [31:0] I_out
);

  logic [31:0] regs_q [32];
  logic [31:0] ir_q, a_q, b_q, pc_q, imm_q;
  logic [31:0] a_d, b_d, imm_d;
  logic [4:0]  rs1, rs2;

  function automatic logic [31:0] imm_decode(input logic [31:0] ir);
    logic [31:0] imm;
    imm = '0;
    case (ir[6:0])
      7'b0110111, 7'b0010111: imm = {ir[31:12], 12'b0};
      7'b1101111: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      7'b1100111, 7'b0000011: imm = {{20{ir[31]}}, ir[31:20]};
      7'b0010011: begin
        // Shift-immediates carry a zero-extended shamt; funct7 bits are not part of it.
        if (ir[13:12] == 2'b01) imm = {27'b0, ir[24:20]};
        else                    imm = {{20{ir[31]}}, ir[31:20]};
      end
      7'b1100011: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      default:    imm = '0;
    endcase
    return imm;
  endfunction

  // x0 reads zero; a write landing on the same edge is forwarded.
  function automatic logic [31:0] read_port(input logic [4:0]  rs,
                                            input logic [31:0] rf_val,
                                            input logic [4:0]  wa,
                                            input logic [31:0] wd);
    logic [31:0] v;
    v = rf_val;
    if (rs == 5'd0)    v = '0;
    else if (rs == wa) v = wd;
    return v;
  endfunction

  always_comb begin
    rs1   = IR[19:15];
    rs2   = IR[24:20];
    a_d   = read_port(rs1, regs_q[rs1], WB_address, WB_data);
    b_d   = read_port(rs2, regs_q[rs2], WB_address, WB_data);
    imm_d = imm_decode(IR);
  end

  // Register file: reset clears every entry and wins over the write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (WB_address != 5'd0) begin
      regs_q[WB_address] <= WB_data;
    end
  end

  // Stage boundary toward execute.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else begin
      ir_q  <= IR;
      a_q   <= a_d;
      b_q   <= b_d;
      pc_q  <= PC;
      imm_q <= imm_d;
    end
  end

  assign IR_out = ir_q;
  assign A_out  = a_q;
  assign B_out  = b_q;
  assign PC_out = pc_q;
  assign I_out  = imm_q;

endmodule

// File: tb/tb_read_stage.sv
// Directed bench for read_stage: register file fill, operand reads, bypass, immediates, reset.
module tb_read_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] IR, WB_data, PC;
  logic [4:0]  WB_address;
  logic [31:0] IR_out, A_out, B_out, PC_out, I_out;

  int n_tests = 0;
  int n_fail  = 0;

  read_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IR         (IR),
    .WB_data    (WB_data),
    .WB_address (WB_address),
    .PC         (PC),
    .IR_out     (IR_out),
    .A_out      (A_out),
    .B_out      (B_out),
    .PC_out     (PC_out),
    .I_out      (I_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, then sample just after the next rising edge.
  task automatic cyc(input logic [31:0] ir, input logic [31:0] pc,
                     input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    IR = ir; PC = pc; WB_address = wa; WB_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pipe(input string tag, input logic [31:0] ir, input logic [31:0] pc);
    chk({tag, ".ir"}, IR_out, ir);
    chk({tag, ".pc"}, PC_out, pc);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, 5'd1, 7'b0110011};
  endfunction

  logic [31:0] ir_v;

  initial begin
    rst_n = 1'b0; IR = '0; PC = '0; WB_address = '0; WB_data = '0;

    // Reset holds outputs at zero even with live inputs.
    cyc(32'h12345678, 32'h0000_0100, 5'd3, 32'hCAFE_F00D);
    chk("rst.a", A_out, 32'h0);
    chk("rst.b", B_out, 32'h0);
    chk("rst.i", I_out, 32'h0);
    chk_pipe("rst", 32'h0, 32'h0);

    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) cyc(32'h0, 32'h0, r[4:0], r);

    // Operand reads, writes on x0 ignored meanwhile.
    for (int a = 2; a < 32; a += 14) begin
      ir_v = rtype(a[4:0], 5'(a + 1));
      cyc(ir_v, 32'h1000 + a, 5'd0, 32'hFFFF_FFFF);
      chk("add.a", A_out, a);
      chk("add.b", B_out, a + 1);
      chk("add.i", I_out, 32'h0);
      chk_pipe("add", ir_v, 32'h1000 + a);
    end

    cyc(rtype(5'd0, 5'd7), 32'h2000, 5'd0, 32'h1234);
    chk("x0.a", A_out, 32'h0);
    chk("x0.b", B_out, 32'h7);

    // Same-edge write is forwarded, then read from the array.
    cyc(rtype(5'd5, 5'd6), 32'h2004, 5'd5, 32'hDEAD);
    chk("byp.a", A_out, 32'hDEAD);
    chk("byp.b", B_out, 32'h6);
    cyc(rtype(5'd6, 5'd5), 32'h2008, 5'd0, 32'h5A5A);
    chk("byp2.a", A_out, 32'h6);
    chk("byp2.b", B_out, 32'hDEAD);
    cyc(rtype(5'd0, 5'd0), 32'h200C, 5'd0, 32'h5A5A);
    chk("wb0.a", A_out, 32'h0);

    // Immediate decode per format.
    cyc(32'hABCDE0B7, 32'h3000, 5'd0, 32'h0); chk("lui",   I_out, 32'hABCDE000);
    chk_pipe("lui", 32'hABCDE0B7, 32'h3000);
    cyc(32'h12345017, 32'h3004, 5'd0, 32'h0); chk("auipc", I_out, 32'h12345000);
    cyc(32'h80000013, 32'h3008, 5'd0, 32'h0); chk("addi",  I_out, 32'hFFFFF800);
    cyc(32'h40705013, 32'h300C, 5'd0, 32'h0); chk("srai",  I_out, 32'h00000007);
    cyc(32'h41F01013, 32'h3010, 5'd0, 32'h0); chk("slli",  I_out, 32'h0000001F);
    cyc(32'h8000006F, 32'h3014, 5'd0, 32'h0); chk("jal",   I_out, 32'hFFF00000);
    cyc(32'hFFF00067, 32'h3018, 5'd0, 32'h0); chk("jalr",  I_out, 32'hFFFFFFFF);
    cyc(32'h00400003, 32'h301C, 5'd0, 32'h0); chk("load",  I_out, 32'h00000004);
    cyc(32'h80000063, 32'h3020, 5'd0, 32'h0); chk("beq",   I_out, 32'hFFFFF000);
    cyc(32'h00006463, 32'h3024, 5'd0, 32'h0); chk("bltu",  I_out, 32'h00000008);
    cyc(32'h7E000FA3, 32'h3028, 5'd0, 32'h0); chk("sw.p",  I_out, 32'h000007FF);
    cyc(32'hFE000FA3, 32'h302C, 5'd0, 32'h0); chk("sw.n",  I_out, 32'hFFFFFFFF);
    cyc(32'h80000033, 32'h3030, 5'd0, 32'h0); chk("rtype", I_out, 32'h0);

    // Mid-stream reset beats a pending write and clears the file.
    rst_n = 1'b0;
    cyc(rtype(5'd9, 5'd31), 32'h4000, 5'd9, 32'h5555);
    chk("mrst.a", A_out, 32'h0);
    chk("mrst.b", B_out, 32'h0);
    chk("mrst.i", I_out, 32'h0);
    chk_pipe("mrst", 32'h0, 32'h0);
    rst_n = 1'b1;
    cyc(rtype(5'd9, 5'd31), 32'h4004, 5'd0, 32'h0);
    chk("post.a", A_out, 32'h0);
    chk("post.b", B_out, 32'h0);
    chk_pipe("post", rtype(5'd9, 5'd31), 32'h4004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
